// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - button conditioning, gravity timer and command arbiter for the tetris core
// Optional soft-drop button path is enabled with TETRIS_SOFT_DROP_EN.
module tetris_input_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [26:0] GRAVITY_TICKS   = 27'd50000000,
  parameter logic [25:0] REPEAT_DELAY    = 26'd25000000,
  parameter logic [25:0] REPEAT_RATE     = 26'd5000000,
  parameter logic [7:0]  MIN_GAP         = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
`ifdef TETRIS_SOFT_DROP_EN
  input  logic       btn_down,
`endif
  output logic [2:0] ctrl
);

`ifdef TETRIS_SOFT_DROP_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? int'(REPEAT_DELAY) : int'(REPEAT_RATE);
  localparam int DEB_W   = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam int GRAV_W  = $clog2(int'(GRAVITY_TICKS) + 1);
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int GAP_W   = $clog2(int'(MIN_GAP) + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(int'(DEBOUNCE_CYCLES) - 1);
  localparam logic [GRAV_W-1:0] GRAV_FULL = GRAV_W'(GRAVITY_TICKS);
`ifdef TETRIS_SOFT_DROP_EN
  localparam logic [GRAV_W-1:0] GRAV_SOFT = GRAV_W'(GRAVITY_TICKS / 8);
`endif
  localparam logic [REP_W-1:0]  REP_DLY   = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0]  REP_PER   = REP_W'(REPEAT_RATE);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(int'(MIN_GAP) - 1);

  localparam int S_HOLD  = 0;
  localparam int S_ROT   = 1;
  localparam int S_LEFT  = 2;
  localparam int S_RIGHT = 3;
  localparam int S_BAR   = 4;
  localparam int S_DOWN  = 5;

  logic [NB-1:0]     raw;
  logic [NB-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]     stable_q, stable_d, prev_q, prev_d, rise;
  logic [DEB_W-1:0]  deb_cnt_q [NB];
  logic [DEB_W-1:0]  deb_cnt_d [NB];
  logic [REP_W-1:0]  rep_cnt_q [2];
  logic [REP_W-1:0]  rep_cnt_d [2];
  logic [1:0]        rep_on_q, rep_on_d, rep_set;
  logic [5:0]        pend_q, pend_d, pend_set, pend_clr, pick;
  logic [GRAV_W-1:0] grav_q, grav_d, grav_limit;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        ctrl_q, ctrl_d, code;
  logic              issue, bar_issue, grav_req;

`ifdef TETRIS_SOFT_DROP_EN
  assign raw = {btn_down, btn};
`else
  assign raw = btn;
`endif
  assign ctrl = ctrl_q;

  // Synchronizer and debouncer: stable only follows sync after DEBOUNCE_CYCLES differing cycles in a row
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    rise = stable_q & ~prev_q;
  end

  // Left/right auto-repeat: first period is REPEAT_DELAY, later ones REPEAT_RATE
  always_comb begin
    rep_set = '0;
    for (int j = 0; j < 2; j++) begin
      rep_cnt_d[j] = '0;
      rep_on_d[j]  = 1'b0;
      if (stable_q[S_LEFT + j]) begin
        if (rep_cnt_q[j] == (rep_on_q[j] ? REP_PER : REP_DLY)) begin
          rep_set[j]   = 1'b1;
          rep_cnt_d[j] = REP_W'(1);
          rep_on_d[j]  = 1'b1;
        end else begin
          rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
          rep_on_d[j]  = rep_on_q[j];
        end
      end
    end
  end

  always_comb begin
    grav_limit = GRAV_FULL;
`ifdef TETRIS_SOFT_DROP_EN
    if (stable_q[S_DOWN]) grav_limit = GRAV_SOFT;
`endif
    issue = (gap_q == '0) && (pend_q != '0);
    pick  = '0;
    code  = 3'd0;
    if (pend_q[S_BAR]) begin
      pick[S_BAR] = 1'b1;   code = 3'd6;
    end else if (pend_q[S_HOLD]) begin
      pick[S_HOLD] = 1'b1;  code = 3'd1;
    end else if (pend_q[S_ROT]) begin
      pick[S_ROT] = 1'b1;   code = 3'd2;
    end else if (pend_q[S_LEFT]) begin
      pick[S_LEFT] = 1'b1;  code = 3'd3;
    end else if (pend_q[S_RIGHT]) begin
      pick[S_RIGHT] = 1'b1; code = 3'd4;
    end else if (pend_q[S_DOWN]) begin
      pick[S_DOWN] = 1'b1;  code = 3'd5;
    end
    bar_issue = issue && pick[S_BAR];

    // Request is raised as the counter enters its last tick, so the DOWN issues exactly at the wrap
    grav_req = !bar_issue && ((grav_q == grav_limit - 2'd2) || (grav_q >= grav_limit));
    grav_d   = (bar_issue || (grav_q >= grav_limit - 1'b1)) ? '0 : grav_q + 1'b1;

    pend_set          = '0;
    pend_set[S_HOLD]  = rise[S_HOLD];
    pend_set[S_ROT]   = rise[S_ROT];
    pend_set[S_LEFT]  = rise[S_LEFT] | rep_set[0];
    pend_set[S_RIGHT] = rise[S_RIGHT] | rep_set[1];
    pend_set[S_BAR]   = rise[S_BAR];
    pend_set[S_DOWN]  = grav_req;
`ifdef TETRIS_SOFT_DROP_EN
    pend_set[S_DOWN]  = grav_req | rise[S_DOWN];
`endif
    pend_clr = issue ? pick : '0;
    if (bar_issue) pend_clr[S_DOWN] = 1'b1;
    pend_d = (pend_q & ~pend_clr) | pend_set;

    ctrl_d = issue ? code : 3'd0;
    gap_d  = issue ? GAP_LOAD : ((gap_q != '0) ? gap_q - 1'b1 : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
      rep_on_q <= '0;
      pend_q   <= '0;
      grav_q   <= '0;
      gap_q    <= '0;
      ctrl_q   <= 3'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= rep_cnt_d[j];
      rep_on_q <= rep_on_d;
      pend_q   <= pend_d;
      grav_q   <= grav_d;
      gap_q    <= gap_d;
      ctrl_q   <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb/tb_tetris_input_ctrl.sv - self-checking bench for tetris_input_ctrl with a behavioural command model
module tb_tetris_input_ctrl;
  localparam int DEB = 4;
  localparam int GT  = 100;
  localparam int RD  = 20;
  localparam int RR  = 10;
  localparam int MG  = 8;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic [2:0] ctrl;
`ifdef TETRIS_SOFT_DROP_EN
  logic       btn_down;
  assign btn_down = 1'b0;
`endif

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .GRAVITY_TICKS  (27'd100),
    .REPEAT_DELAY   (26'd20),
    .REPEAT_RATE    (26'd10),
    .MIN_GAP        (8'd8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
`ifdef TETRIS_SOFT_DROP_EN
    .btn_down(btn_down),
`endif
    .ctrl    (ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_cyc[$];
  int ev_code[$];

  // Model state: sources 0 hold, 1 rotate, 2 left, 3 right, 4 bar, 5 down
  int m_s1[5], m_s2[5], m_st[5], m_prev[5], m_run[5];
  int m_held[2];
  int m_age, m_gap, m_ctrl;
  int m_pend[6];
  int ORD[6]  = '{4, 0, 1, 2, 3, 5};
  int CODE[6] = '{1, 2, 3, 4, 6, 5};

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
    for (int i = 0; i < 6; i++) m_pend[i] = 0;
    m_held[0] = 0; m_held[1] = 0;
    m_age = 0; m_gap = 0; m_ctrl = 0;
  endtask

  task automatic model_step(input logic [4:0] b);
    int n_st[5];
    int n_run[5];
    int rise[5];
    int rq[2];
    int set[6];
    int pick;
    int grav_req;
    for (int i = 0; i < 5; i++) begin
      rise[i] = (m_st[i] == 1 && m_prev[i] == 0) ? 1 : 0;
      n_st[i] = m_st[i];
      n_run[i] = 0;
      if (m_s2[i] != m_st[i]) begin
        n_run[i] = m_run[i] + 1;
        if (n_run[i] == DEB) begin
          n_st[i] = m_s2[i];
          n_run[i] = 0;
        end
      end
    end
    for (int j = 0; j < 2; j++)
      rq[j] = (m_st[2+j] == 1 && m_held[j] >= RD && ((m_held[j] - RD) % RR) == 0) ? 1 : 0;
    pick = -1;
    if (m_gap == 0)
      for (int k = 0; k < 6; k++)
        if (pick < 0 && m_pend[ORD[k]] == 1) pick = ORD[k];
    grav_req = ((m_age % GT) == GT - 2 && pick != 4) ? 1 : 0;
    set[0] = rise[0];
    set[1] = rise[1];
    set[2] = rise[2] | rq[0];
    set[3] = rise[3] | rq[1];
    set[4] = rise[4];
    set[5] = grav_req;
    for (int i = 0; i < 6; i++) begin
      if (i == pick || (i == 5 && pick == 4)) m_pend[i] = 0;
      if (set[i] == 1) m_pend[i] = 1;
    end
    m_ctrl = (pick >= 0) ? CODE[pick] : 0;
    m_gap  = (pick >= 0) ? MG - 1 : ((m_gap > 0) ? m_gap - 1 : 0);
    m_age  = (pick == 4) ? 0 : m_age + 1;
    for (int j = 0; j < 2; j++) m_held[j] = (m_st[2+j] == 1) ? m_held[j] + 1 : 0;
    for (int i = 0; i < 5; i++) begin
      m_prev[i] = m_st[i];
      m_st[i]   = n_st[i];
      m_run[i]  = n_run[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = int'(b[i]);
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare at the following negedge
  task automatic cycle(input logic [4:0] b);
    btn = b;
    @(posedge clk);
    model_step(b);
    cyc++;
    @(negedge clk);
    checks++;
    if (ctrl !== 3'(m_ctrl)) begin
      errors++;
      $display("FAIL model_ctrl cyc=%0d actual=%0d expected=%0d", cyc, ctrl, m_ctrl);
    end
    if (ctrl !== 3'd0) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(int'(ctrl));
    end
  endtask

  task automatic do_reset();
    btn = 5'd0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    ev_cyc.delete();
    ev_code.delete();
  endtask

  task automatic test_reset();
    btn = 5'b11111;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ctrl !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl actual=%0d expected=0", ctrl);
    end
    do_reset();
    repeat (20) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 0) begin
      errors++;
      $display("FAIL reset_idle actual=%0d pulses expected=0", ev_cyc.size());
    end
  endtask

  task automatic test_gravity();
    do_reset();
    repeat (350) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 3) begin
      errors++;
      $display("FAIL gravity_count actual=%0d expected=3", ev_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ev_code[k] != 5 || ev_cyc[k] != 100 * (k + 1)) begin
          errors++;
          $display("FAIL gravity_pulse%0d actual=code%0d@%0d expected=code5@%0d", k, ev_code[k], ev_cyc[k], 100 * (k + 1));
        end
      end
    end
  endtask

  task automatic test_rotate_clean();
    do_reset();
    repeat (5) cycle(5'd0);
    repeat (30) cycle(5'b00010);
    repeat (20) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++;
      $display("FAIL rotate_clean_count actual=%0d expected=1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_code[0] != 2 || ev_cyc[0] != 5 + 8) begin
        errors++;
        $display("FAIL rotate_clean_latency actual=code%0d@%0d expected=code2@13", ev_code[0], ev_cyc[0]);
      end
    end
  endtask

  task automatic test_rotate_bounce();
    do_reset();
    repeat (5) cycle(5'd0);
    for (int k = 0; k < 12; k++) cycle(((k / 2) % 2 == 0) ? 5'b00010 : 5'b00000);
    repeat (30) cycle(5'b00010);
    repeat (20) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++;
      $display("FAIL rotate_bounce_count actual=%0d expected=1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_code[0] != 2 || ev_cyc[0] != 17 + 8) begin
        errors++;
        $display("FAIL rotate_bounce_pulse actual=code%0d@%0d expected=code2@25", ev_code[0], ev_cyc[0]);
      end
    end
  endtask

  task automatic test_left_repeat();
    int exp_t[4];
    exp_t = '{13, 33, 43, 53};
    do_reset();
    repeat (5) cycle(5'd0);
    repeat (50) cycle(5'b00100);
    repeat (20) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 4) begin
      errors++;
      $display("FAIL left_repeat_count actual=%0d expected=4", ev_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ev_code[k] != 3 || ev_cyc[k] != exp_t[k]) begin
          errors++;
          $display("FAIL left_repeat%0d actual=code%0d@%0d expected=code3@%0d", k, ev_code[k], ev_cyc[k], exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_bar_rotate();
    int exp_c[3];
    int exp_t[3];
    exp_c = '{6, 2, 5};
    exp_t = '{13, 21, 113};
    do_reset();
    repeat (5) cycle(5'd0);
    repeat (20) cycle(5'b10010);
    repeat (105) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 3) begin
      errors++;
      $display("FAIL bar_rotate_count actual=%0d expected=3", ev_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ev_code[k] != exp_c[k] || ev_cyc[k] != exp_t[k]) begin
          errors++;
          $display("FAIL bar_rotate%0d actual=code%0d@%0d expected=code%0d@%0d", k, ev_code[k], ev_cyc[k], exp_c[k], exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_reset_in_gap();
    do_reset();
    repeat (5) cycle(5'd0);
    repeat (8) cycle(5'b10010);
    checks++;
    if (ev_cyc.size() != 1 || ctrl !== 3'd6) begin
      errors++;
      $display("FAIL gap_setup actual=%0d pulses ctrl=%0d expected=1 pulse ctrl=6", ev_cyc.size(), ctrl);
    end
    btn = 5'd0;
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== 3'd0) begin
      errors++;
      $display("FAIL reset_async_ctrl actual=%0d expected=0", ctrl);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    ev_cyc.delete();
    ev_code.delete();
    repeat (60) cycle(5'd0);
    checks++;
    if (ev_cyc.size() != 0) begin
      errors++;
      $display("FAIL reset_gap_after actual=%0d pulses expected=0", ev_cyc.size());
    end
  endtask

  task automatic test_random();
    logic [4:0] lv;
    int burst;
    lv = 5'd0;
    burst = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(3, 10);
      if (burst > 0) begin
        burst--;
        if ($urandom_range(0, 1) == 1) lv[$urandom_range(0, 4)] ^= 1'b1;
      end else begin
        for (int i = 0; i < 5; i++)
          if ($urandom_range(0, 39) == 0) lv[i] = ~lv[i];
      end
      cycle(lv);
    end
    repeat (40) cycle(5'd0);
  endtask

  initial begin
    reset = 1'b1;
    btn = 5'd0;
    model_reset();
    test_reset();
    test_gravity();
    test_rotate_clean();
    test_rotate_bounce();
    test_left_repeat();
    test_bar_rotate();
    test_reset_in_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
